// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory stage: ls_info bit positions, FSM states, access sizes.
// Also holds the ls_info priority decode and the alignment check used by the controller.
package mem_ctrl_pkg;

    localparam int LS_LB  = 0;
    localparam int LS_LH  = 1;
    localparam int LS_LW  = 2;
    localparam int LS_LD  = 3;
    localparam int LS_LBU = 4;
    localparam int LS_LHU = 5;
    localparam int LS_LWU = 6;
    localparam int LS_SB  = 7;
    localparam int LS_SH  = 8;
    localparam int LS_SW  = 9;
    localparam int LS_SD  = 10;
    localparam int LS_W   = 11;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

    typedef struct packed {
        logic  vld;
        logic  wen;
        logic  sign;
        size_t size;
    } ls_dec_t;

    // Lowest set bit wins when the one-hot is violated.
    function automatic ls_dec_t ls_decode(input logic [LS_W-1:0] info);
        ls_dec_t d;
        d.vld  = 1'b1;
        d.wen  = 1'b0;
        d.sign = 1'b0;
        d.size = SZ_B;
        if      (info[LS_LB])  begin d.sign = 1'b1; d.size = SZ_B; end
        else if (info[LS_LH])  begin d.sign = 1'b1; d.size = SZ_H; end
        else if (info[LS_LW])  begin d.sign = 1'b1; d.size = SZ_W; end
        else if (info[LS_LD])  begin d.sign = 1'b1; d.size = SZ_D; end
        else if (info[LS_LBU]) d.size = SZ_B;
        else if (info[LS_LHU]) d.size = SZ_H;
        else if (info[LS_LWU]) d.size = SZ_W;
        else if (info[LS_SB])  begin d.wen = 1'b1; d.size = SZ_B; end
        else if (info[LS_SH])  begin d.wen = 1'b1; d.size = SZ_H; end
        else if (info[LS_SW])  begin d.wen = 1'b1; d.size = SZ_W; end
        else if (info[LS_SD])  begin d.wen = 1'b1; d.size = SZ_D; end
        else                   d.vld = 1'b0;
        return d;
    endfunction

    function automatic logic [7:0] size_mask(input size_t s);
        case (s)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic misaligned(input size_t s, input logic [2:0] off);
        case (s)
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            SZ_D:    return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load formatter: shifts the aligned doubleword down by the byte offset,
// truncates to the access size and sign- or zero-extends to 64 bits.
module mem_load_align
    import mem_ctrl_pkg::*;
(
    input  logic [63:0] i_rdata,
    input  logic [2:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    output logic [63:0] o_data
);

    logic [63:0] w_sh;

    assign w_sh = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_data = w_sh;
        case (i_size)
            SZ_B:    o_data = {{56{i_sign & w_sh[7]}},  w_sh[7:0]};
            SZ_H:    o_data = {{48{i_sign & w_sh[15]}}, w_sh[15:0]};
            SZ_W:    o_data = {{32{i_sign & w_sh[31]}}, w_sh[31:0]};
            default: o_data = w_sh;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: one dcache transaction per load/store, pipeline stalled until DONE
// (min 3 cycles op->done). Optional MEM_ACCESS_MISALIGN_TRAP_EN short-circuits misaligned ops.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_i_valid,
    input  logic [10:0] mem_i_ls_info,
    input  logic [63:0] mem_i_addr,
    input  logic [63:0] mem_i_wdata,
    output logic        dc_o_req_valid,
    input  logic        dc_i_req_ready,
    output logic [63:0] dc_o_addr,
    output logic        dc_o_wen,
    output logic [7:0]  dc_o_wstrb,
    output logic [63:0] dc_o_wdata,
    input  logic        dc_i_resp_valid,
    input  logic [63:0] dc_i_rdata,
    output logic        ctrl_o_stall,
    output logic        ctrl_o_done,
    output logic [63:0] ctrl_o_load_data,
    output logic        ctrl_o_timeout,
    output logic        ctrl_o_misalign
);

    state_t      r_state, w_state_nxt;
    ls_dec_t     w_dec;
    logic        w_mem_op, w_misalign, w_wd_fire;
    logic [2:0]  w_off;
    logic [63:0] w_fmt;
    logic [63:0] r_addr, r_wdata, r_load_data;
    logic [7:0]  r_wstrb;
    logic [1:0]  r_size;
    logic        r_sign, r_wen, r_timeout;
    logic [31:0] r_wd_cnt;

    assign w_dec    = ls_decode(mem_i_ls_info);
    assign w_mem_op = mem_i_valid & w_dec.vld;
    assign w_off    = mem_i_addr[2:0];
    assign w_wd_fire = (TIMEOUT_CYC != 0) && (r_wd_cnt == TIMEOUT_CYC - 1);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_misalign = misaligned(w_dec.size, w_off);

    always_ff @(posedge clk) begin
        if (rst)
            r_misalign <= 1'b0;
        else if (r_state == IDLE && w_mem_op)
            r_misalign <= w_misalign;
    end

    assign ctrl_o_misalign = r_misalign & (r_state == DONE);
`else
    assign w_misalign      = 1'b0;
    assign ctrl_o_misalign = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_mem_op) w_state_nxt = w_misalign ? DONE : REQ;
            REQ:     if (dc_i_req_ready) w_state_nxt = WAIT;
            WAIT:    if (dc_i_resp_valid || w_wd_fire) w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_size      <= '0;
            r_sign      <= 1'b0;
            r_wen       <= 1'b0;
            r_load_data <= '0;
            r_timeout   <= 1'b0;
            r_wd_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            // A trapped access never reaches the dcache, so its fields are not latched.
            if (r_state == IDLE && w_mem_op && !w_misalign) begin
                r_addr  <= mem_i_addr;
                r_size  <= w_dec.size;
                r_sign  <= w_dec.sign;
                r_wen   <= w_dec.wen;
                r_wstrb <= size_mask(w_dec.size) << w_off;
                r_wdata <= mem_i_wdata << {w_off, 3'b000};
            end
            if (r_state == WAIT) begin
                r_wd_cnt <= r_wd_cnt + 1;
                if (dc_i_resp_valid) begin
                    if (!r_wen)
                        r_load_data <= w_fmt;
                end else if (w_wd_fire) begin
                    r_timeout   <= 1'b1;
                    r_load_data <= '0;
                end
            end else begin
                r_wd_cnt <= '0;
            end
        end
    end

    mem_load_align u_load_align (
        .i_rdata (dc_i_rdata),
        .i_off   (r_addr[2:0]),
        .i_size  (r_size),
        .i_sign  (r_sign),
        .o_data  (w_fmt)
    );

    assign dc_o_req_valid   = (r_state == REQ) & ~rst;
    assign dc_o_addr        = {r_addr[63:3], 3'b000};
    assign dc_o_wen         = r_wen;
    assign dc_o_wstrb       = r_wstrb;
    assign dc_o_wdata       = r_wdata;
    assign ctrl_o_stall     = (r_state == IDLE && w_mem_op) || r_state == REQ || r_state == WAIT;
    assign ctrl_o_done      = (r_state == DONE);
    assign ctrl_o_load_data = r_load_data;
    assign ctrl_o_timeout   = r_timeout;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, stores, backpressure, watchdog, mid-flight reset.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_i_valid;
    logic [10:0] mem_i_ls_info;
    logic [63:0] mem_i_addr;
    logic [63:0] mem_i_wdata;
    logic        dc_o_req_valid;
    logic        dc_i_req_ready;
    logic [63:0] dc_o_addr;
    logic        dc_o_wen;
    logic [7:0]  dc_o_wstrb;
    logic [63:0] dc_o_wdata;
    logic        dc_i_resp_valid;
    logic [63:0] dc_i_rdata;
    logic        ctrl_o_stall;
    logic        ctrl_o_done;
    logic [63:0] ctrl_o_load_data;
    logic        ctrl_o_timeout;
    logic        ctrl_o_misalign;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_i_valid      (mem_i_valid),
        .mem_i_ls_info    (mem_i_ls_info),
        .mem_i_addr       (mem_i_addr),
        .mem_i_wdata      (mem_i_wdata),
        .dc_o_req_valid   (dc_o_req_valid),
        .dc_i_req_ready   (dc_i_req_ready),
        .dc_o_addr        (dc_o_addr),
        .dc_o_wen         (dc_o_wen),
        .dc_o_wstrb       (dc_o_wstrb),
        .dc_o_wdata       (dc_o_wdata),
        .dc_i_resp_valid  (dc_i_resp_valid),
        .dc_i_rdata       (dc_i_rdata),
        .ctrl_o_stall     (ctrl_o_stall),
        .ctrl_o_done      (ctrl_o_done),
        .ctrl_o_load_data (ctrl_o_load_data),
        .ctrl_o_timeout   (ctrl_o_timeout),
        .ctrl_o_misalign  (ctrl_o_misalign)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Load with immediate ready and response on the cycle after acceptance.
    task automatic do_load(input string tag, input logic [10:0] ls, input logic [63:0] addr,
                           input logic [63:0] exp_addr, input logic [63:0] rd, input logic [63:0] exp);
        cyc(); mem_i_valid = 1'b1; mem_i_ls_info = ls; mem_i_addr = addr; dc_i_req_ready = 1'b1;
        smp(); chk1({tag, "_stall_c0"}, ctrl_o_stall, 1'b1); chk1({tag, "_req_c0"}, dc_o_req_valid, 1'b0);
        cyc();
        smp(); chk1({tag, "_req_c1"}, dc_o_req_valid, 1'b1); chk64({tag, "_addr"}, dc_o_addr, exp_addr);
        chk1({tag, "_wen"}, dc_o_wen, 1'b0); chk1({tag, "_stall_c1"}, ctrl_o_stall, 1'b1);
        cyc(); dc_i_resp_valid = 1'b1; dc_i_rdata = rd;
        smp(); chk1({tag, "_stall_c2"}, ctrl_o_stall, 1'b1); chk1({tag, "_done_c2"}, ctrl_o_done, 1'b0);
        cyc(); dc_i_resp_valid = 1'b0; dc_i_rdata = 64'h0;
        smp(); chk1({tag, "_done_c3"}, ctrl_o_done, 1'b1); chk1({tag, "_stall_c3"}, ctrl_o_stall, 1'b0);
        chk64({tag, "_ldata"}, ctrl_o_load_data, exp);
        cyc(); mem_i_valid = 1'b0;
        smp(); chk1({tag, "_done_c4"}, ctrl_o_done, 1'b0); chk64({tag, "_ldata_hold"}, ctrl_o_load_data, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mem_i_valid = 1'b0; mem_i_ls_info = 11'h000; mem_i_addr = 64'h0;
        mem_i_wdata = 64'h0; dc_i_req_ready = 1'b0; dc_i_resp_valid = 1'b0; dc_i_rdata = 64'h0;
        cyc(); cyc();
        smp();
        chk1("rst_req", dc_o_req_valid, 1'b0);   chk64("rst_addr", dc_o_addr, 64'h0);
        chk1("rst_wen", dc_o_wen, 1'b0);         chk64("rst_wstrb", {56'h0, dc_o_wstrb}, 64'h0);
        chk64("rst_wdata", dc_o_wdata, 64'h0);   chk1("rst_done", ctrl_o_done, 1'b0);
        chk64("rst_ldata", ctrl_o_load_data, 64'h0); chk1("rst_timeout", ctrl_o_timeout, 1'b0);
        chk1("rst_misalign", ctrl_o_misalign, 1'b0); chk1("rst_stall", ctrl_o_stall, 1'b0);
        cyc(); rst = 1'b0;
        // Non-memory instruction: no stall, no request.
        cyc(); mem_i_valid = 1'b1; mem_i_ls_info = 11'h000; mem_i_addr = 64'h1000;
        smp(); chk1("nonmem_stall", ctrl_o_stall, 1'b0);
        cyc(); mem_i_valid = 1'b0;
        smp(); chk1("nonmem_req", dc_o_req_valid, 1'b0);

        do_load("ld",  11'h008, 64'h1000, 64'h1000, 64'h1122334455667788, 64'h1122334455667788);
        do_load("lb",  11'h001, 64'h1003, 64'h1000, 64'h0000000080000000, 64'hFFFFFFFFFFFFFF80);
        do_load("lbu", 11'h010, 64'h1003, 64'h1000, 64'h0000000080000000, 64'h0000000000000080);
        // lh and lbu both set: lh (lower index) must win.
        do_load("prio", 11'h012, 64'h1004, 64'h1000, 64'h0000800100000000, 64'hFFFFFFFFFFFF8001);
        do_load("lwu", 11'h040, 64'h1004, 64'h1000, 64'h89ABCDEF00000000, 64'h0000000089ABCDEF);
        do_load("lbu2", 11'h010, 64'h1003, 64'h1000, 64'h0000000080000000, 64'h0000000000000080);

        // sh with ready held low for three cycles; pipeline inputs change underneath.
        cyc(); mem_i_valid = 1'b1; mem_i_ls_info = 11'h100; mem_i_addr = 64'h2006;
        mem_i_wdata = 64'hABCD; dc_i_req_ready = 1'b0;
        smp(); chk1("sh_stall_c0", ctrl_o_stall, 1'b1);
        cyc(); mem_i_addr = 64'hDEADBEEF00000005; mem_i_wdata = 64'h5555555555555555;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk1("sh_req_hold", dc_o_req_valid, 1'b1);   chk64("sh_addr", dc_o_addr, 64'h2000);
            chk64("sh_wstrb", {56'h0, dc_o_wstrb}, 64'hC0); chk64("sh_wdata", dc_o_wdata, 64'hABCD000000000000);
            chk1("sh_wen", dc_o_wen, 1'b1);              chk1("sh_stall", ctrl_o_stall, 1'b1);
            cyc();
        end
        dc_i_req_ready = 1'b1;
        smp(); chk1("sh_req_acc", dc_o_req_valid, 1'b1);
        cyc(); dc_i_req_ready = 1'b0; dc_i_resp_valid = 1'b1;
        smp(); chk1("sh_req_wait", dc_o_req_valid, 1'b0); chk1("sh_done_wait", ctrl_o_done, 1'b0);
        cyc(); dc_i_resp_valid = 1'b0;
        smp(); chk1("sh_done", ctrl_o_done, 1'b1); chk64("sh_ldata_keep", ctrl_o_load_data, 64'h80);
        // Back-to-back: sd seen in IDLE on the cycle after DONE.
        cyc(); mem_i_ls_info = 11'h400; mem_i_addr = 64'h5008; mem_i_wdata = 64'h0102030405060708;
        smp(); chk1("b2b_stall", ctrl_o_stall, 1'b1); chk1("b2b_done", ctrl_o_done, 1'b0);
        cyc(); dc_i_req_ready = 1'b1;
        smp(); chk1("sd_req", dc_o_req_valid, 1'b1); chk64("sd_addr", dc_o_addr, 64'h5008);
        chk64("sd_wstrb", {56'h0, dc_o_wstrb}, 64'hFF); chk64("sd_wdata", dc_o_wdata, 64'h0102030405060708);
        cyc(); dc_i_req_ready = 1'b0; dc_i_resp_valid = 1'b1; dc_i_rdata = 64'hFFFFFFFFFFFFFFFF;
        cyc(); dc_i_resp_valid = 1'b0;
        smp(); chk1("sd_done", ctrl_o_done, 1'b1); chk64("sd_ldata_keep", ctrl_o_load_data, 64'h80);
        cyc(); mem_i_valid = 1'b0;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        cyc(); mem_i_valid = 1'b1; mem_i_ls_info = 11'h004; mem_i_addr = 64'h3002; dc_i_req_ready = 1'b1;
        smp(); chk1("mis_stall_c0", ctrl_o_stall, 1'b1); chk1("mis_req_c0", dc_o_req_valid, 1'b0);
        cyc();
        smp(); chk1("mis_done", ctrl_o_done, 1'b1); chk1("mis_flag", ctrl_o_misalign, 1'b1);
        chk1("mis_req_c1", dc_o_req_valid, 1'b0); chk64("mis_ldata", ctrl_o_load_data, 64'h80);
        cyc(); mem_i_valid = 1'b0; dc_i_req_ready = 1'b0;
        smp(); chk1("mis_flag_clr", ctrl_o_misalign, 1'b0); chk1("mis_done_clr", ctrl_o_done, 1'b0);
`else
        // Misaligned sw proceeds with strobes truncated at the doubleword boundary.
        cyc(); mem_i_valid = 1'b1; mem_i_ls_info = 11'h200; mem_i_addr = 64'h3006;
        mem_i_wdata = 64'h11223344; dc_i_req_ready = 1'b1;
        cyc();
        smp(); chk1("sw_mis_req", dc_o_req_valid, 1'b1); chk64("sw_mis_wstrb", {56'h0, dc_o_wstrb}, 64'hC0);
        chk64("sw_mis_wdata", dc_o_wdata, 64'h3344000000000000); chk1("sw_mis_flag", ctrl_o_misalign, 1'b0);
        cyc(); dc_i_req_ready = 1'b0; dc_i_resp_valid = 1'b1;
        cyc(); dc_i_resp_valid = 1'b0;
        smp(); chk1("sw_mis_done", ctrl_o_done, 1'b1); chk1("sw_mis_flag_done", ctrl_o_misalign, 1'b0);
        cyc(); mem_i_valid = 1'b0;
`endif

        // Watchdog: no response, DONE four cycles after WAIT entry.
        cyc(); mem_i_valid = 1'b1; mem_i_ls_info = 11'h008; mem_i_addr = 64'h4000; dc_i_req_ready = 1'b1;
        cyc();
        smp(); chk1("wd_req", dc_o_req_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(); dc_i_req_ready = 1'b0;
            smp(); chk1("wd_no_done", ctrl_o_done, 1'b0); chk1("wd_stall", ctrl_o_stall, 1'b1);
            chk1("wd_no_to", ctrl_o_timeout, 1'b0);
        end
        cyc();
        smp(); chk1("wd_done", ctrl_o_done, 1'b1); chk1("wd_timeout", ctrl_o_timeout, 1'b1);
        chk64("wd_ldata", ctrl_o_load_data, 64'h0);
        cyc(); mem_i_valid = 1'b0;
        cyc();
        smp(); chk1("wd_sticky", ctrl_o_timeout, 1'b1); chk1("wd_done_clr", ctrl_o_done, 1'b0);

        // Reset during REQ drops the request in that same cycle.
        cyc(); mem_i_valid = 1'b1; mem_i_ls_info = 11'h008; mem_i_addr = 64'h6000; dc_i_req_ready = 1'b0;
        cyc(); rst = 1'b1;
        smp(); chk1("rstreq_req", dc_o_req_valid, 1'b0);
        cyc(); rst = 1'b0; mem_i_valid = 1'b0;
        smp(); chk1("rstreq_stall", ctrl_o_stall, 1'b0); chk1("rstreq_to_clr", ctrl_o_timeout, 1'b0);
        chk1("rstreq_req_after", dc_o_req_valid, 1'b0);

        // Reset during WAIT, then a stale response.
        cyc(); mem_i_valid = 1'b1; mem_i_ls_info = 11'h004; mem_i_addr = 64'h6004; dc_i_req_ready = 1'b1;
        cyc();
        cyc(); dc_i_req_ready = 1'b0; rst = 1'b1;
        smp(); chk1("rstw_req", dc_o_req_valid, 1'b0);
        cyc(); rst = 1'b0; mem_i_valid = 1'b0; dc_i_resp_valid = 1'b1; dc_i_rdata = 64'h7777777777777777;
        smp(); chk1("rstw_done", ctrl_o_done, 1'b0); chk1("rstw_stall", ctrl_o_stall, 1'b0);
        chk64("rstw_addr", dc_o_addr, 64'h0); chk1("rstw_wen", dc_o_wen, 1'b0);
        chk64("rstw_ldata", ctrl_o_load_data, 64'h0); chk1("rstw_req2", dc_o_req_valid, 1'b0);
        cyc(); dc_i_resp_valid = 1'b0;
        smp(); chk1("rstw_done2", ctrl_o_done, 1'b0); chk64("rstw_ldata2", ctrl_o_load_data, 64'h0);
        chk1("rstw_timeout", ctrl_o_timeout, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
